// File: rtl/pwm_duty_capture_if.sv
// Signal bundle between the PWM duty capture block and its consumer.
// The consumer (master) drives the raw PWM line and observes the measurement results.
interface pwm_duty_capture_if #(
    parameter int CNT_W = 16
) ();
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [3:0]       duty_tenths;
    logic             meas_valid;
    logic             active;
    logic             signal_lost;
    logic             overrun;

    modport master (
        output pwm_in,
        input  high_cnt, period_cnt, duty_tenths, meas_valid, active, signal_lost, overrun
    );

    modport slave (
        input  pwm_in,
        output high_cnt, period_cnt, duty_tenths, meas_valid, active, signal_lost, overrun
    );
endinterface

// File: rtl/pwm_duty_capture.sv
// Measures high time and period of an external PWM waveform and reports duty in tenths
// through a 4-step restoring divider; flags lost/stuck signals and dropped captures.
module pwm_duty_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    pwm_duty_capture_if.slave  bus
);
    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;
    localparam int NW = CNT_W + 4;
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    // One restoring-division step: returns {quotient bit, remainder}.
    function automatic logic [NW:0] div_step(input logic [NW-1:0] n,
                                             input logic [CNT_W-1:0] d,
                                             input logic [1:0] i);
        logic [NW-1:0] ds;
        ds = NW'(d) << i;
        if (n >= ds) begin
            div_step = {1'b1, n - ds};
        end else begin
            div_step = {1'b0, n};
        end
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_d_r;
    logic                   s_s, rise_s, fall_s;
    logic [1:0]             state_r, state_nx_s;
    logic [CNT_W-1:0]       per_ctr_r, per_nx_s, hi_ctr_r, hi_nx_s, hi_latch_r, latch_nx_s;
    logic                   capture_s, timeout_s;
    logic                   busy_r;
    logic [1:0]             div_step_r;
    logic [NW-1:0]          div_n_r;
    logic [CNT_W-1:0]       div_d_r, res_high_r;
    logic [3:0]             div_q_r;
    logic [NW:0]            step_res_s;
    logic [CNT_W-1:0]       high_cnt_r, period_cnt_r;
    logic [3:0]             duty_r;
    logic                   valid_r, active_r, lost_r, overrun_r;

    assign s_s        = sync_r[SYNC_STAGES-1];
    assign rise_s     = s_s & ~s_d_r;
    assign fall_s     = ~s_s & s_d_r;
    assign step_res_s = div_step(div_n_r, div_d_r, div_step_r);

    // Input synchronizer and one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            s_d_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.pwm_in};
            s_d_r  <= s_s;
        end
    end

    // Next-state and counter logic; periods chain rise to rise with no gap.
    always_comb begin
        state_nx_s = state_r;
        per_nx_s   = per_ctr_r;
        hi_nx_s    = hi_ctr_r;
        latch_nx_s = hi_latch_r;
        capture_s  = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (rise_s) begin
                    state_nx_s = ST_HIGH;
                    per_nx_s   = ONE_C;
                    hi_nx_s    = ONE_C;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_HIGH: begin
                if (fall_s) begin
                    state_nx_s = ST_LOW;
                    latch_nx_s = hi_ctr_r;
                    per_nx_s   = per_ctr_r + ONE_C;
                end else if (per_ctr_r >= TIMEOUT_C) begin
                    state_nx_s = ST_WAIT;
                    timeout_s  = 1'b1;
                end else begin
                    per_nx_s   = per_ctr_r + ONE_C;
                    hi_nx_s    = hi_ctr_r + ONE_C;
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    state_nx_s = ST_HIGH;
                    capture_s  = 1'b1;
                    per_nx_s   = ONE_C;
                    hi_nx_s    = ONE_C;
                end else if (per_ctr_r >= TIMEOUT_C) begin
                    state_nx_s = ST_WAIT;
                    timeout_s  = 1'b1;
                end else begin
                    per_nx_s   = per_ctr_r + ONE_C;
                end
            end
            default: begin
                state_nx_s = ST_WAIT;
            end
        endcase
    end

    // FSM state and measurement counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_WAIT;
            per_ctr_r  <= '0;
            hi_ctr_r   <= '0;
            hi_latch_r <= '0;
            active_r   <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            per_ctr_r  <= per_nx_s;
            hi_ctr_r   <= hi_nx_s;
            hi_latch_r <= latch_nx_s;
            active_r   <= (state_nx_s == ST_HIGH) || (state_nx_s == ST_LOW);
        end
    end

    // Divider sequencing and registered result outputs; a timeout pre-empts any division.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r       <= 1'b0;
            div_step_r   <= 2'd0;
            div_n_r      <= '0;
            div_d_r      <= '0;
            div_q_r      <= 4'd0;
            res_high_r   <= '0;
            high_cnt_r   <= '0;
            period_cnt_r <= '0;
            duty_r       <= 4'd0;
            valid_r      <= 1'b0;
            lost_r       <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (timeout_s) begin
            busy_r       <= 1'b0;
            high_cnt_r   <= '0;
            period_cnt_r <= '0;
            duty_r       <= s_s ? 4'd10 : 4'd0;
            valid_r      <= 1'b1;
            lost_r       <= 1'b1;
        end else begin
            valid_r <= 1'b0;
            if (busy_r) begin
                div_n_r             <= step_res_s[NW-1:0];
                div_q_r[div_step_r] <= step_res_s[NW];
                if (div_step_r == 2'd0) begin
                    busy_r       <= 1'b0;
                    high_cnt_r   <= res_high_r;
                    period_cnt_r <= div_d_r;
                    duty_r       <= {div_q_r[3:1], step_res_s[NW]};
                    valid_r      <= 1'b1;
                    lost_r       <= 1'b0;
                end else begin
                    div_step_r <= div_step_r - 2'd1;
                end
                if (capture_s) begin
                    overrun_r <= 1'b1;
                end else begin
                    overrun_r <= overrun_r;
                end
            end else if (capture_s) begin
                busy_r     <= 1'b1;
                div_step_r <= 2'd3;
                div_n_r    <= (NW'(hi_latch_r) << 3) + (NW'(hi_latch_r) << 1);
                div_d_r    <= per_ctr_r;
                div_q_r    <= 4'd0;
                res_high_r <= hi_latch_r;
            end else begin
                busy_r <= 1'b0;
            end
        end
    end

    assign bus.high_cnt    = high_cnt_r;
    assign bus.period_cnt  = period_cnt_r;
    assign bus.duty_tenths = duty_r;
    assign bus.meas_valid  = valid_r;
    assign bus.active      = active_r;
    assign bus.signal_lost = lost_r;
    assign bus.overrun     = overrun_r;
endmodule

// File: tb/tb_pwm_duty_capture.sv
// Self-checking bench for pwm_duty_capture: a timestamp-based event model checks every
// cycle, a vector table checks settled results, and directed sequences cover corner cases.
module tb_pwm_duty_capture;
    localparam int CNT_W = 16;
    localparam int SYNC  = 2;
    localparam int TMO   = 60;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_duty_capture_if #(.CNT_W(CNT_W)) bus ();

    pwm_duty_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {int t; int hi; int per;} res_t;
    typedef struct {int hi; int lo; int reps; int e_hi; int e_per; int e_duty; bit e_ovr;} vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: event timestamps, not counters
    bit   hist[$];
    res_t pend[$];
    bit   m_counting, m_fall_seen;
    int   m_rise_t, m_fall_t, m_div_free, t;
    logic [CNT_W-1:0] e_high, e_per;
    logic [3:0]       e_duty;
    bit   e_valid, e_active, e_lost, e_ovr;

    int cyc = 0;
    int last_valid_c = 0;
    int last_rise_c  = 0;
    int valid_count  = 0;
    bit drv_prev     = 1'b0;

    vec_t vecs[9];

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic check_outputs();
        n_tests++;
        if (bus.high_cnt !== e_high || bus.period_cnt !== e_per || bus.duty_tenths !== e_duty ||
            bus.meas_valid !== e_valid || bus.active !== e_active ||
            bus.signal_lost !== e_lost || bus.overrun !== e_ovr) begin
            n_fail++;
            $display("FAIL cycle_check t=%0d got hi=%0d per=%0d duty=%0d v=%b a=%b lost=%b ovr=%b want hi=%0d per=%0d duty=%0d v=%b a=%b lost=%b ovr=%b",
                     t, bus.high_cnt, bus.period_cnt, bus.duty_tenths, bus.meas_valid, bus.active,
                     bus.signal_lost, bus.overrun, e_high, e_per, e_duty, e_valid, e_active, e_lost, e_ovr);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC + 1; i++) hist.push_back(1'b0);
        pend.delete();
        m_counting = 0; m_fall_seen = 0;
        m_rise_t = 0; m_fall_t = 0; m_div_free = 0; t = 0;
        e_high = '0; e_per = '0; e_duty = 4'd0;
        e_valid = 0; e_active = 0; e_lost = 0; e_ovr = 0;
    endtask

    // Computes what the outputs must be in the next cycle from edge timestamps.
    task automatic model_step();
        bit s_now, s_prev, rise, fall;
        res_t r;
        int sz;
        sz     = hist.size();
        s_now  = hist[sz-SYNC];
        s_prev = hist[sz-SYNC-1];
        rise   = s_now & ~s_prev;
        fall   = ~s_now & s_prev;
        e_valid = 0;
        if (m_counting && !rise && !fall && (t - m_rise_t) >= TMO) begin
            m_counting = 0; m_fall_seen = 0;
            pend.delete(); m_div_free = t;
            e_high = '0; e_per = '0; e_duty = s_now ? 4'd10 : 4'd0;
            e_valid = 1; e_lost = 1;
        end else begin
            if (pend.size() > 0 && pend[0].t == t + 1) begin
                r = pend.pop_front();
                e_high = CNT_W'(r.hi); e_per = CNT_W'(r.per);
                e_duty = 4'((10 * r.hi) / r.per);
                e_valid = 1; e_lost = 0;
            end
            if (rise) begin
                if (m_counting && m_fall_seen) begin
                    if (t >= m_div_free) begin
                        pend.push_back('{t + 5, m_fall_t - m_rise_t, t - m_rise_t});
                        m_div_free = t + 5;
                    end else begin
                        e_ovr = 1;
                    end
                end
                m_counting = 1; m_rise_t = t; m_fall_seen = 0;
            end
            if (fall && m_counting) begin
                m_fall_seen = 1; m_fall_t = t;
            end
        end
        e_active = m_counting;
        t++;
    endtask

    task automatic step_body(input bit b);
        cyc++;
        if (bus.meas_valid === 1'b1) begin
            last_valid_c = cyc;
            valid_count++;
        end
        check_outputs();
        model_step();
        bus.pwm_in = b;
        if (b && !drv_prev) last_rise_c = cyc;
        drv_prev = b;
        hist.push_back(b);
        if (hist.size() > 8) hist.delete(0);
    endtask

    task automatic cycle(input bit b);
        @(posedge clk);
        #1;
        step_body(b);
    endtask

    task automatic run_period(input int h, input int l);
        repeat (h) cycle(1'b1);
        repeat (l) cycle(1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.pwm_in = 1'b0;
        #1;
        n_tests++;
        if (bus.high_cnt !== '0 || bus.period_cnt !== '0 || bus.duty_tenths !== 4'd0 ||
            bus.meas_valid !== 1'b0 || bus.active !== 1'b0 || bus.signal_lost !== 1'b0 ||
            bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got hi=%0d per=%0d duty=%0d v=%b a=%b lost=%b ovr=%b want all zero",
                     bus.high_cnt, bus.period_cnt, bus.duty_tenths, bus.meas_valid, bus.active,
                     bus.signal_lost, bus.overrun);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drv_prev = 1'b0;
        valid_count = 0;
        step_body(1'b0);
    endtask

    initial begin
        vecs[0] = '{5, 5, 4, 5, 10, 5, 1'b0};
        vecs[1] = '{3, 7, 4, 3, 10, 3, 1'b0};
        vecs[2] = '{9, 1, 4, 9, 10, 9, 1'b0};
        vecs[3] = '{2, 5, 4, 2, 7, 2, 1'b0};
        vecs[4] = '{1, 1, 12, 1, 2, 5, 1'b1};
        vecs[5] = '{1, 4, 4, 1, 5, 2, 1'b0};
        vecs[6] = '{4, 1, 4, 4, 5, 8, 1'b0};
        vecs[7] = '{6, 9, 3, 6, 15, 4, 1'b0};
        vecs[8] = '{1, 3, 6, 1, 4, 2, 1'b1};

        bus.pwm_in = 1'b0;
        model_reset();
        #23;

        // vector table: settled results after a few periods of each pattern
        for (int v = 0; v < 9; v++) begin
            do_reset();
            for (int r = 0; r < vecs[v].reps; r++) run_period(vecs[v].hi, vecs[v].lo);
            repeat (8) cycle(1'b0);
            chk($sformatf("vec%0d_high", v), int'(bus.high_cnt), vecs[v].e_hi);
            chk($sformatf("vec%0d_period", v), int'(bus.period_cnt), vecs[v].e_per);
            chk($sformatf("vec%0d_duty", v), int'(bus.duty_tenths), vecs[v].e_duty);
            chk($sformatf("vec%0d_overrun", v), int'(bus.overrun), int'(vecs[v].e_ovr));
        end

        // result latency: valid 7 cycles after driven rise (2 sync + 5 divide)
        do_reset();
        run_period(3, 7);
        run_period(3, 7);
        chk("latency_duty3", last_valid_c - last_rise_c, 7);
        run_period(9, 1);
        run_period(9, 1);
        chk("duty9_value", int'(bus.duty_tenths), 9);

        // stuck high then stuck low, then recovery
        run_period(5, 5); run_period(5, 5);
        repeat (TMO + 15) cycle(1'b1);
        chk("stuck_hi_latency", last_valid_c - last_rise_c, TMO + 3);
        chk("stuck_hi_duty", int'(bus.duty_tenths), 10);
        chk("stuck_hi_period", int'(bus.period_cnt), 0);
        chk("stuck_hi_lost", int'(bus.signal_lost), 1);
        chk("stuck_hi_active", int'(bus.active), 0);
        repeat (3) run_period(5, 5);
        repeat (TMO + 15) cycle(1'b0);
        chk("stuck_lo_duty", int'(bus.duty_tenths), 0);
        chk("stuck_lo_lost", int'(bus.signal_lost), 1);
        repeat (3) run_period(5, 5);
        repeat (8) cycle(1'b0);
        chk("recover_lost", int'(bus.signal_lost), 0);
        chk("recover_duty", int'(bus.duty_tenths), 5);

        // reset in the middle of a division, then no result until two rises
        do_reset();
        run_period(5, 5); run_period(5, 5);
        repeat (4) cycle(1'b1);
        do_reset();
        run_period(5, 5);
        repeat (6) cycle(1'b1);
        chk("post_reset_no_valid", valid_count, 0);
        repeat (6) cycle(1'b1);
        chk("post_reset_first_valid", valid_count, 1);

        // randomized periods and occasional stuck segments
        do_reset();
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(9, 0) == 0) begin
                bit lvl;
                lvl = 1'($urandom_range(1, 0));
                repeat (TMO + 10) cycle(lvl);
            end else begin
                run_period(int'($urandom_range(8, 1)), int'($urandom_range(8, 1)));
            end
        end
        repeat (10) cycle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
